flow_control_sequencer: RTL and testbench
=========================================

Name: flow_control_sequencer

Overview:
- Multi-cycle controller behind the program decoder.
- Takes the decoded control-flow flags and the Mini ALU result, and sequences the stack memory for CALL/RET/PUSH/POP/SYS.
- Owns the stack pointer and kernel-mode bit, issues PC-load and register-write pulses, and stalls fetch via busy while an operation is in flight.

Parameters:
STACK_BASE, 16'hFFFF, SP reset value (empty stack); stack grows downward.
STACK_LIMIT, 16'hFF00, lowest writable stack address (full stack).
SYS_VECTOR, 16'h0010, PC loaded on SYS.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  flags/operands valid; accepted only when busy=0
JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag, GSA_flag, SWITCH_flag, SYS_flag, Kernel_flag  in  1 each  decoded flags
target  in  32  Mini ALU result; [15:0] is the jump target
push_data  in  32  value to push (f register)
pop_reg  in  8  destination register code for POP/GSA
PC_pos  in  16  PC of current instruction
mem_req  out  1  stack memory request, held until mem_ack
mem_we  out  1  1=write, 0=read
mem_addr  out  16  stack address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion
pc_load  out  1  one-cycle pulse; PC <= pc_next
pc_next  out  16  new PC
reg_we  out  1  one-cycle register-file write pulse
reg_waddr  out  8  register code
reg_wdata  out  32  write data
busy  out  1  high whenever state != IDLE
kernel_mode  out  1  privilege bit
sp  out  16  stack pointer
stack_fault  out  1  one-cycle pulse on overflow/underflow

Behaviour:
- Reset (async, immediate):
  - state=IDLE; mem_req=0, mem_we=0, pc_load=0, reg_we=0, stack_fault=0.
  - mem_addr, mem_wdata, pc_next, reg_waddr, reg_wdata = 0.
  - sp=STACK_BASE; kernel_mode=1.
  - Reset mid-operation abandons the transaction; no retry.
- Acceptance: in IDLE with instr_valid=1 and any flag set. Priority if several flags are set: CALL > RET > SYS > PUSH > POP > GSA > SWITCH > JMP. No flag set: remain IDLE.
- States: IDLE, WR (write pending), RD (read pending), FIN (emit pulses, busy still 1). FIN always returns to IDLE.
- Operations, accepted at cycle N:
  - JMP: IDLE->FIN. pc_load=1 at N+1 with pc_next=target[15:0]. If Kernel_flag=1, kernel_mode<=1 at the same edge (GTP).
  - SWITCH: as JMP, plus kernel_mode<=0.
  - GSA: IDLE->FIN. reg_we at N+1, reg_waddr=pop_reg, reg_wdata={16'b0,sp}.
  - PUSH: IDLE->WR. From N+1: mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=push_data. On the mem_ack cycle: sp<=sp-1, go FIN (no pulses).
  - CALL: as PUSH with mem_wdata={16'b0,PC_pos+1}. FIN then pulses pc_load with pc_next=target[15:0].
  - SYS: as CALL with pc_next=SYS_VECTOR; kernel_mode<=1 in FIN.
  - POP: IDLE->RD. mem_req=1, mem_we=0, mem_addr=sp. On ack: sp<=sp+1, latch rdata, go FIN. FIN pulses reg_we with reg_waddr=pop_reg.
  - RET: as POP. FIN pulses pc_load with pc_next=rdata[15:0].
- Operands (target, push_data, pop_reg, PC_pos) are latched at acceptance; later input changes are ignored.
- mem_req and address/data stay stable until the ack cycle inclusive; mem_req drops the cycle after ack.
- mem_ack when mem_req=0 is ignored.
- Latency: JMP-class completes in 2 cycles (busy high 1 cycle). Memory ops take 2 + wait cycles.
- Overflow: write-type op with sp==STACK_LIMIT.
  - No memory access; stack_fault pulses at N+1; go FIN with no pc_load/reg_we; sp unchanged.
- Underflow: read-type op with sp==STACK_BASE. Same handling.
- sp arithmetic is 16-bit; PC_pos+1 wraps 16'hFFFF->16'h0000.

Test Plan:
- Reset with rst_n=0 mid-WR (mem_req=1) -> mem_req=0 immediately, sp=16'hFFFF, kernel_mode=1, busy=0.
- JMP with target=32'h0000_1234, Kernel_flag=1 -> at N+1 pc_load=1, pc_next=16'h1234, busy=1; kernel_mode=1; IDLE at N+2.
- CALL, PC_pos=16'h0040, target=16'h0200, mem_ack after 3 cycles -> write addr 16'hFFFE, wdata 32'h41, sp=16'hFFFE, then pc_load with pc_next=16'h0200.
- RET right after that CALL, rdata=32'h41 -> read addr 16'hFFFE, sp=16'hFFFF, pc_load with pc_next=16'h0041.
- PUSH with sp forced to STACK_LIMIT by 255 pushes, then a 256th PUSH -> stack_fault pulse, no mem_req, sp=16'hFF00. POP at reset -> stack_fault, no reg_we.
- CALL+JMP flags both set -> CALL executed only. instr_valid while busy -> ignored; SWITCH target=16'h0300 -> kernel_mode=0, pc_next=16'h0300.

Source files
------------

// File: rtl/flow_control_sequencer_if.sv
// Stack-memory bus between the flow-control sequencer and the stack memory.
//   mem_req   : request, held until the cycle mem_ack is seen
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : stack address
//   mem_wdata : write data
//   mem_rdata : read data, valid together with mem_ack
//   mem_ack   : one-cycle completion strobe from the memory
// master = sequencer side, slave = memory side.
interface flow_control_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/flow_control_sequencer.sv
// Flow-control sequencer sitting behind the program decoder.
// Accepts decoded control-flow flags plus the Mini ALU result and sequences
// the stack memory for CALL/RET/PUSH/POP/SYS. Owns the stack pointer and the
// kernel-mode bit, issues one-cycle PC-load and register-write pulses, and
// holds busy high while an operation is in flight.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   instr_valid, *_flag : decoded instruction, accepted only while busy=0
//   target              : Mini ALU result, [15:0] is the jump target
//   push_data           : value pushed by PUSH
//   pop_reg             : destination register code for POP/GSA
//   PC_pos              : PC of the current instruction
//   mem                 : stack-memory bus (master side)
//   pc_load/pc_next     : one-cycle PC load pulse and new PC
//   reg_we/reg_waddr/reg_wdata : one-cycle register-file write
//   busy, kernel_mode, sp, stack_fault : status
module flow_control_sequencer #(
    parameter logic [15:0] STACK_BASE  = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00,
    parameter logic [15:0] SYS_VECTOR  = 16'h0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        JMP_flag,
    input  logic        CALL_flag,
    input  logic        RET_flag,
    input  logic        PUSH_flag,
    input  logic        POP_flag,
    input  logic        GSA_flag,
    input  logic        SWITCH_flag,
    input  logic        SYS_flag,
    input  logic        Kernel_flag,
    input  logic [31:0] target,
    input  logic [31:0] push_data,
    input  logic [7:0]  pop_reg,
    input  logic [15:0] PC_pos,
    flow_control_sequencer_if.master mem,
    output logic        pc_load,
    output logic [15:0] pc_next,
    output logic        reg_we,
    output logic [7:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        busy,
    output logic        kernel_mode,
    output logic [15:0] sp,
    output logic        stack_fault
);

    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_JMP, OP_SWITCH, OP_GSA, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_SYS
    } op_t;

    state_t      state_reg, state_next;
    op_t         op_reg, op_next;
    op_t         acc_op;
    logic [15:0] sp_reg, sp_next;
    logic        kernel_reg, kernel_next;
    logic [15:0] target_reg, target_next;
    logic [7:0]  dest_reg, dest_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        pc_load_reg, pc_load_next;
    logic [15:0] pc_next_reg, pc_next_next;
    logic        reg_we_reg, reg_we_next;
    logic [7:0]  reg_waddr_reg, reg_waddr_next;
    logic [31:0] reg_wdata_reg, reg_wdata_next;
    logic        fault_reg, fault_next;

    // Only the low half of the ALU result is a PC value.
    logic unused_target_hi;
    assign unused_target_hi = ^target[31:16];

    // Priority decode of the flags: CALL > RET > SYS > PUSH > POP > GSA > SWITCH > JMP.
    always_comb begin
        acc_op = OP_NONE;
        if (CALL_flag)        acc_op = OP_CALL;
        else if (RET_flag)    acc_op = OP_RET;
        else if (SYS_flag)    acc_op = OP_SYS;
        else if (PUSH_flag)   acc_op = OP_PUSH;
        else if (POP_flag)    acc_op = OP_POP;
        else if (GSA_flag)    acc_op = OP_GSA;
        else if (SWITCH_flag) acc_op = OP_SWITCH;
        else if (JMP_flag)    acc_op = OP_JMP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= OP_NONE;
            sp_reg        <= STACK_BASE;
            kernel_reg    <= 1'b1;
            target_reg    <= 16'h0000;
            dest_reg      <= 8'h00;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 16'h0000;
            mem_wdata_reg <= 32'h0000_0000;
            pc_load_reg   <= 1'b0;
            pc_next_reg   <= 16'h0000;
            reg_we_reg    <= 1'b0;
            reg_waddr_reg <= 8'h00;
            reg_wdata_reg <= 32'h0000_0000;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            sp_reg        <= sp_next;
            kernel_reg    <= kernel_next;
            target_reg    <= target_next;
            dest_reg      <= dest_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            pc_load_reg   <= pc_load_next;
            pc_next_reg   <= pc_next_next;
            reg_we_reg    <= reg_we_next;
            reg_waddr_reg <= reg_waddr_next;
            reg_wdata_reg <= reg_wdata_next;
            fault_reg     <= fault_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        sp_next        = sp_reg;
        kernel_next    = kernel_reg;
        target_next    = target_reg;
        dest_next      = dest_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        pc_load_next   = 1'b0;
        pc_next_next   = pc_next_reg;
        reg_we_next    = 1'b0;
        reg_waddr_next = reg_waddr_reg;
        reg_wdata_next = reg_wdata_reg;
        fault_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (instr_valid) begin
                    case (acc_op)
                        OP_JMP, OP_SWITCH: begin
                            state_next   = FIN;
                            pc_load_next = 1'b1;
                            pc_next_next = target[15:0];
                            if (acc_op == OP_SWITCH) kernel_next = 1'b0;
                            else if (Kernel_flag)    kernel_next = 1'b1;
                        end
                        OP_GSA: begin
                            state_next     = FIN;
                            reg_we_next    = 1'b1;
                            reg_waddr_next = pop_reg;
                            reg_wdata_next = {16'h0000, sp_reg};
                        end
                        OP_PUSH, OP_CALL, OP_SYS: begin
                            if (sp_reg == STACK_LIMIT) begin
                                // Overflow: no memory access, just the fault pulse.
                                state_next = FIN;
                                fault_next = 1'b1;
                            end else begin
                                state_next     = WR;
                                op_next        = acc_op;
                                target_next    = target[15:0];
                                mem_req_next   = 1'b1;
                                mem_we_next    = 1'b1;
                                mem_addr_next  = sp_reg - 16'd1;
                                mem_wdata_next = (acc_op == OP_PUSH) ? push_data
                                                                     : {16'h0000, PC_pos + 16'd1};
                            end
                        end
                        OP_POP, OP_RET: begin
                            if (sp_reg == STACK_BASE) begin
                                // Underflow: nothing on the stack to read.
                                state_next = FIN;
                                fault_next = 1'b1;
                            end else begin
                                state_next    = RD;
                                op_next       = acc_op;
                                dest_next     = pop_reg;
                                mem_req_next  = 1'b1;
                                mem_we_next   = 1'b0;
                                mem_addr_next = sp_reg;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WR: begin
                if (mem.mem_ack) begin
                    state_next   = FIN;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    sp_next      = sp_reg - 16'd1;
                    if (op_reg == OP_CALL) begin
                        pc_load_next = 1'b1;
                        pc_next_next = target_reg;
                    end else if (op_reg == OP_SYS) begin
                        pc_load_next = 1'b1;
                        pc_next_next = SYS_VECTOR;
                        kernel_next  = 1'b1;
                    end
                end
            end
            RD: begin
                if (mem.mem_ack) begin
                    state_next   = FIN;
                    mem_req_next = 1'b0;
                    sp_next      = sp_reg + 16'd1;
                    if (op_reg == OP_RET) begin
                        pc_load_next = 1'b1;
                        pc_next_next = mem.mem_rdata[15:0];
                    end else begin
                        reg_we_next    = 1'b1;
                        reg_waddr_next = dest_reg;
                        reg_wdata_next = mem.mem_rdata;
                    end
                end
            end
            FIN: begin
                // Pulses registered on the way in are visible here; just drain.
                state_next = IDLE;
                op_next    = OP_NONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign pc_load       = pc_load_reg;
    assign pc_next       = pc_next_reg;
    assign reg_we        = reg_we_reg;
    assign reg_waddr     = reg_waddr_reg;
    assign reg_wdata     = reg_wdata_reg;
    assign busy          = (state_reg != IDLE);
    assign kernel_mode   = kernel_reg;
    assign sp            = sp_reg;
    assign stack_fault   = fault_reg;

endmodule

// File: tb/tb_flow_control_sequencer.sv
module tb_flow_control_sequencer;

    localparam logic [8:0] F_JMP    = 9'h001;
    localparam logic [8:0] F_CALL   = 9'h002;
    localparam logic [8:0] F_RET    = 9'h004;
    localparam logic [8:0] F_PUSH   = 9'h008;
    localparam logic [8:0] F_POP    = 9'h010;
    localparam logic [8:0] F_GSA    = 9'h020;
    localparam logic [8:0] F_SWITCH = 9'h040;
    localparam logic [8:0] F_SYS    = 9'h080;
    localparam logic [8:0] F_KERN   = 9'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag;
    logic        GSA_flag, SWITCH_flag, SYS_flag, Kernel_flag;
    logic [31:0] target;
    logic [31:0] push_data;
    logic [7:0]  pop_reg;
    logic [15:0] PC_pos;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        reg_we;
    logic [7:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy;
    logic        kernel_mode;
    logic [15:0] sp;
    logic        stack_fault;

    int n_tests = 0;
    int n_fail  = 0;

    flow_control_sequencer_if mem_bus ();

    flow_control_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .JMP_flag    (JMP_flag),
        .CALL_flag   (CALL_flag),
        .RET_flag    (RET_flag),
        .PUSH_flag   (PUSH_flag),
        .POP_flag    (POP_flag),
        .GSA_flag    (GSA_flag),
        .SWITCH_flag (SWITCH_flag),
        .SYS_flag    (SYS_flag),
        .Kernel_flag (Kernel_flag),
        .target      (target),
        .push_data   (push_data),
        .pop_reg     (pop_reg),
        .PC_pos      (PC_pos),
        .mem         (mem_bus),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .busy        (busy),
        .kernel_mode (kernel_mode),
        .sp          (sp),
        .stack_fault (stack_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_flags(input logic [8:0] f);
        JMP_flag    = f[0];
        CALL_flag   = f[1];
        RET_flag    = f[2];
        PUSH_flag   = f[3];
        POP_flag    = f[4];
        GSA_flag    = f[5];
        SWITCH_flag = f[6];
        SYS_flag    = f[7];
        Kernel_flag = f[8];
    endtask

    // Present an instruction for one edge; returns at the negedge of cycle N+1.
    task automatic start(input string name, input logic [8:0] f);
        $display("[TB] %0t issue %s flags=%h", $time, name, f);
        set_flags(f);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        set_flags(9'h000);
    endtask

    // One-cycle ack; returns at the negedge of the FIN cycle.
    task automatic ack_now(input logic [31:0] rd);
        mem_bus.mem_rdata = rd;
        mem_bus.mem_ack   = 1'b1;
        @(negedge clk);
        mem_bus.mem_ack   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        set_flags(9'h000);
        target = 32'h0;
        push_data = 32'h0;
        pop_reg = 8'h0;
        PC_pos = 16'h0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_sp", {16'h0, sp}, 32'h0000_FFFF);
        check("rst_kernel", {31'h0, kernel_mode}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check("rst_pc_next", {16'h0, pc_next}, 32'h0);

        // POP on empty stack -> underflow
        pop_reg = 8'h05;
        start("POP_underflow", F_POP);
        check("uf_fault", {31'h0, stack_fault}, 32'h1);
        check("uf_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check("uf_busy", {31'h0, busy}, 32'h1);
        check("uf_reg_we", {31'h0, reg_we}, 32'h0);
        @(negedge clk);
        check("uf_fault_end", {31'h0, stack_fault}, 32'h0);
        check("uf_idle", {31'h0, busy}, 32'h0);
        check("uf_sp", {16'h0, sp}, 32'h0000_FFFF);

        // JMP with Kernel_flag
        target = 32'h0000_1234;
        start("JMP", F_JMP | F_KERN);
        check("jmp_pc_load", {31'h0, pc_load}, 32'h1);
        check("jmp_pc_next", {16'h0, pc_next}, 32'h0000_1234);
        check("jmp_busy", {31'h0, busy}, 32'h1);
        check("jmp_kernel", {31'h0, kernel_mode}, 32'h1);
        @(negedge clk);
        check("jmp_idle", {31'h0, busy}, 32'h0);
        check("jmp_pulse_end", {31'h0, pc_load}, 32'h0);

        // CALL with 2 extra wait cycles; operands change and a JMP is offered while busy
        PC_pos = 16'h0040;
        target = 32'h0000_0200;
        start("CALL", F_CALL);
        check("call_req", {31'h0, mem_bus.mem_req}, 32'h1);
        check("call_we", {31'h0, mem_bus.mem_we}, 32'h1);
        check("call_addr", {16'h0, mem_bus.mem_addr}, 32'h0000_FFFE);
        check("call_wdata", mem_bus.mem_wdata, 32'h0000_0041);
        target = 32'h0000_BEEF;
        PC_pos = 16'h1111;
        set_flags(F_JMP);
        instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("call_hold_req", {31'h0, mem_bus.mem_req}, 32'h1);
        check("call_hold_addr", {16'h0, mem_bus.mem_addr}, 32'h0000_FFFE);
        check("call_hold_wdata", mem_bus.mem_wdata, 32'h0000_0041);
        check("call_sp_pre", {16'h0, sp}, 32'h0000_FFFF);
        check("call_no_pc_load", {31'h0, pc_load}, 32'h0);
        ack_now(32'h0);
        instr_valid = 1'b0;
        set_flags(9'h000);
        check("call_fin_pc_load", {31'h0, pc_load}, 32'h1);
        check("call_fin_pc_next", {16'h0, pc_next}, 32'h0000_0200);
        check("call_fin_sp", {16'h0, sp}, 32'h0000_FFFE);
        check("call_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
        @(negedge clk);
        check("call_idle", {31'h0, busy}, 32'h0);
        check("call_busy_ignored", {16'h0, pc_next}, 32'h0000_0200);

        // RET with one wait cycle
        start("RET", F_RET);
        check("ret_req", {31'h0, mem_bus.mem_req}, 32'h1);
        check("ret_we", {31'h0, mem_bus.mem_we}, 32'h0);
        check("ret_addr", {16'h0, mem_bus.mem_addr}, 32'h0000_FFFE);
        @(negedge clk);
        ack_now(32'h0000_0041);
        check("ret_pc_load", {31'h0, pc_load}, 32'h1);
        check("ret_pc_next", {16'h0, pc_next}, 32'h0000_0041);
        check("ret_sp", {16'h0, sp}, 32'h0000_FFFF);
        @(negedge clk);

        // PUSH / POP / GSA
        push_data = 32'hCAFE_BABE;
        start("PUSH", F_PUSH);
        check("push_addr", {16'h0, mem_bus.mem_addr}, 32'h0000_FFFE);
        check("push_wdata", mem_bus.mem_wdata, 32'hCAFE_BABE);
        ack_now(32'h0);
        check("push_no_pc_load", {31'h0, pc_load}, 32'h0);
        check("push_no_reg_we", {31'h0, reg_we}, 32'h0);
        check("push_sp", {16'h0, sp}, 32'h0000_FFFE);
        @(negedge clk);
        pop_reg = 8'h07;
        start("POP", F_POP);
        check("pop_addr", {16'h0, mem_bus.mem_addr}, 32'h0000_FFFE);
        pop_reg = 8'h09;
        ack_now(32'h1234_5678);
        check("pop_reg_we", {31'h0, reg_we}, 32'h1);
        check("pop_waddr", {24'h0, reg_waddr}, 32'h0000_0007);
        check("pop_wdata", reg_wdata, 32'h1234_5678);
        check("pop_sp", {16'h0, sp}, 32'h0000_FFFF);
        check("pop_no_pc_load", {31'h0, pc_load}, 32'h0);
        @(negedge clk);
        pop_reg = 8'h03;
        start("GSA", F_GSA);
        check("gsa_reg_we", {31'h0, reg_we}, 32'h1);
        check("gsa_waddr", {24'h0, reg_waddr}, 32'h0000_0003);
        check("gsa_wdata", reg_wdata, 32'h0000_FFFF);
        @(negedge clk);
        check("gsa_pulse_end", {31'h0, reg_we}, 32'h0);

        // Stray ack in IDLE is ignored
        $display("[TB] %0t stray ack", $time);
        mem_bus.mem_ack = 1'b1;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        check("stray_busy", {31'h0, busy}, 32'h0);
        check("stray_sp", {16'h0, sp}, 32'h0000_FFFF);

        // CALL and JMP together: CALL wins
        PC_pos = 16'h0100;
        target = 32'h0000_0500;
        start("CALL+JMP", F_CALL | F_JMP);
        check("prio_req", {31'h0, mem_bus.mem_req}, 32'h1);
        check("prio_no_pc_load", {31'h0, pc_load}, 32'h0);
        check("prio_wdata", mem_bus.mem_wdata, 32'h0000_0101);
        ack_now(32'h0);
        check("prio_pc_next", {16'h0, pc_next}, 32'h0000_0500);
        check("prio_sp", {16'h0, sp}, 32'h0000_FFFE);
        @(negedge clk);

        // Kernel-mode transitions
        target = 32'h0000_0300;
        start("SWITCH", F_SWITCH);
        check("sw_pc_next", {16'h0, pc_next}, 32'h0000_0300);
        check("sw_kernel", {31'h0, kernel_mode}, 32'h0);
        @(negedge clk);
        target = 32'h0000_0700;
        start("JMP_GTP", F_JMP | F_KERN);
        check("gtp_kernel", {31'h0, kernel_mode}, 32'h1);
        @(negedge clk);
        target = 32'h0000_0300;
        start("SWITCH", F_SWITCH);
        @(negedge clk);
        target = 32'h0000_0800;
        start("JMP_user", F_JMP);
        check("jmpu_kernel", {31'h0, kernel_mode}, 32'h0);
        check("jmpu_pc_next", {16'h0, pc_next}, 32'h0000_0800);
        @(negedge clk);
        PC_pos = 16'hFFFF;
        start("SYS", F_SYS);
        check("sys_addr", {16'h0, mem_bus.mem_addr}, 32'h0000_FFFD);
        check("sys_wdata_wrap", mem_bus.mem_wdata, 32'h0000_0000);
        ack_now(32'h0);
        check("sys_pc_next", {16'h0, pc_next}, 32'h0000_0010);
        check("sys_pc_load", {31'h0, pc_load}, 32'h1);
        check("sys_kernel", {31'h0, kernel_mode}, 32'h1);
        check("sys_sp", {16'h0, sp}, 32'h0000_FFFD);
        @(negedge clk);

        // Reset in the middle of a write
        start("SWITCH", F_SWITCH);
        @(negedge clk);
        push_data = 32'h0000_0001;
        start("PUSH_reset", F_PUSH);
        check("mid_req", {31'h0, mem_bus.mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check("mid_rst_sp", {16'h0, sp}, 32'h0000_FFFF);
        check("mid_rst_kernel", {31'h0, kernel_mode}, 32'h1);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the stack to STACK_LIMIT, then overflow
        push_data = 32'h0000_00AA;
        for (int i = 0; i < 255; i++) begin
            set_flags(F_PUSH);
            instr_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            instr_valid = 1'b0;
            set_flags(9'h000);
            ack_now(32'h0);
            @(negedge clk);
        end
        $display("[TB] %0t 255 pushes done, sp=%h", $time, sp);
        check("fill_sp", {16'h0, sp}, 32'h0000_FF00);
        start("PUSH_overflow", F_PUSH);
        check("of_fault", {31'h0, stack_fault}, 32'h1);
        check("of_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check("of_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("of_fault_end", {31'h0, stack_fault}, 32'h0);
        check("of_sp", {16'h0, sp}, 32'h0000_FF00);
        check("of_idle", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
